div32_seq: RTL and testbench



---
 rtl/div32_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_div32_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
`timescale 1ns/1ps
// div32_seq -- iterative restoring divider for the MiniMIPS execute stage
// (DIV/DIVU). One trial subtraction per clock; the quotient and remainder
// go to the HI/LO writeback path.
//
// Build option: define DIV_SIGNED_EN to add the sign_op port and signed
// division. Without it the block is a plain unsigned divider.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        division request, honoured only while busy is low
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   sign_op      (DIV_SIGNED_EN only) 1 = signed division
//   busy         high while a division is in flight (CALC or DONE)
//   done         one-cycle pulse, results valid in that cycle
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done
//   div_by_zero  registered flag for the last completed operation
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// CALC   | one restoring step per cycle, WIDTH steps in total
// DONE   | result registers hold the new result, done pulses
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             sign_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    // dvd_q shifts the dividend out at the top while quotient bits enter at
    // the bottom, so after WIDTH steps it holds the raw quotient.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             div_zero;
    logic             last_step;
    logic [WIDTH+1:0] p_shift;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] quo_raw;
    logic [WIDTH-1:0] rem_raw;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign div_zero  = (divisor == '0);
    assign last_step = (state_q == S_CALC) && (cnt_q == LAST_STEP);

    // One restoring step. The extra top bit of trial is the borrow: P stays
    // below 2*divisor, so a set MSB means the subtraction went negative.
    always_comb begin
        p_shift = {p_q, dvd_q[WIDTH-1]};
        trial   = p_shift - {2'b00, dvs_q};
        q_bit   = ~trial[WIDTH+1];
        p_step  = q_bit ? trial[WIDTH:0] : p_shift[WIDTH:0];
        quo_raw = {dvd_q[WIDTH-2:0], q_bit};
        rem_raw = p_step[WIDTH-1:0];
    end

`ifdef DIV_SIGNED_EN
    logic quo_neg_q, quo_neg_d;
    logic rem_neg_q, rem_neg_d;
    logic a_neg, b_neg;

    // The core divides magnitudes; signs are reapplied as the result loads,
    // so 0x80000000 / -1 wraps to 0x80000000 as required.
    always_comb begin
        a_neg   = sign_op & dividend[WIDTH-1];
        b_neg   = sign_op & divisor[WIDTH-1];
        op_a    = a_neg ? -dividend : dividend;
        op_b    = b_neg ? -divisor  : divisor;
        quo_fix = quo_neg_q ? -quo_raw : quo_raw;
        rem_fix = rem_neg_q ? -rem_raw : rem_raw;
    end
`else
    always_comb begin
        op_a    = dividend;
        op_b    = divisor;
        quo_fix = quo_raw;
        rem_fix = rem_raw;
    end
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs (decoded straight from the state flop)
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath next values
    always_comb begin
        p_d   = p_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
`ifdef DIV_SIGNED_EN
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = dividend;
                        dbz_d = 1'b1;
                    end else begin
                        dvd_d = op_a;
                        dvs_d = op_b;
                        p_d   = '0;
                        cnt_d = '0;
`ifdef DIV_SIGNED_EN
                        quo_neg_d = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
`endif
                    end
                end
            end
            S_CALC: begin
                p_d   = p_step;
                dvd_d = quo_raw;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    quo_d = quo_fix;
                    rem_d = rem_fix;
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            p_q   <= p_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
`timescale 1ns/1ps
module tb_div32_seq;

    localparam int NEVER = 32'h7fff_ffff;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef DIV_SIGNED_EN
    logic        sign_op;
`endif
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    div32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .sign_op     (sign_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          done_edge;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          edge_cnt = 0;
    int          acc_edge = NEVER;
    int          free_edge = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        last_dbz = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference: plain integer division; 64-bit signed math avoids overflow
    // for the most-negative / -1 case.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int e);
        exp_t   x;
        longint sa, sbv, sq, sr;
        if (b == 0) begin
            x.q = 32'hFFFF_FFFF;
            x.r = a;
            x.dbz = 1'b1;
            x.done_edge = e;
        end else begin
            if (s) begin
                sa  = longint'($signed(a));
                sbv = longint'($signed(b));
                sq  = sa / sbv;
                sr  = sa % sbv;
                x.q = sq[31:0];
                x.r = sr[31:0];
            end else begin
                x.q = a / b;
                x.r = a % b;
            end
            x.dbz = 1'b0;
            x.done_edge = e + 32;
        end
        return x;
    endfunction

    // Called at a negedge; drives start for exactly one rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        int e;
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        sign_op  = s;
`endif
        start = 1'b1;
        e = edge_cnt + 1;
        if (e >= free_edge) begin
            sb.push_back(model(a, b, s, e));
            acc_edge  = e;
            free_edge = e + ((b == 0) ? 2 : 34);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_free();
        while (edge_cnt + 1 < free_edge) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        sb.delete();
        last_q = '0;
        last_r = '0;
        last_dbz = 1'b0;
        acc_edge = NEVER;
        free_edge = 0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_by_zero", {31'b0, div_by_zero}, 32'd0);
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares against the scoreboard whenever done is presented,
    // and otherwise checks that results are held and busy matches the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'b0, busy},
                {31'b0, (edge_cnt >= acc_edge) && (edge_cnt <= free_edge - 2)});
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, expected done=0 (edge %0d)", edge_cnt);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("latency_edge", edge_cnt, x.done_edge);
                    chk("quotient", quotient, x.q);
                    chk("remainder", remainder, x.r);
                    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, x.dbz});
                    last_q = x.q;
                    last_r = x.r;
                    last_dbz = x.dbz;
                end
            end else begin
                if (sb.size() > 0 && edge_cnt >= sb[0].done_edge) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL missing_done: got done=0, expected done=1 (edge %0d)", edge_cnt);
                    void'(sb.pop_front());
                end
                chk("hold_quotient", quotient, last_q);
                chk("hold_remainder", remainder, last_r);
                chk("hold_div_by_zero", {31'b0, div_by_zero}, {31'b0, last_dbz});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
`ifdef DIV_SIGNED_EN
        sign_op = 1'b0;
`endif
        @(negedge clk);
        do_reset(3);
        @(negedge clk);

        issue(32'd100, 32'd7, 1'b0);
        wait_free();

        // Second start lands in the DONE cycle and must be ignored.
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        while (edge_cnt < acc_edge + 32) @(negedge clk);
        issue(32'd5, 32'd9, 1'b0);
        issue(32'd5, 32'd9, 1'b0);
        wait_free();

        issue(32'd5, 32'd0, 1'b0);
        wait_free();
        issue(32'd8, 32'd2, 1'b0);
        wait_free();

        // Start ignored while busy, then reset mid-operation.
        issue(32'd1000, 32'd3, 1'b0);
        repeat (8) @(negedge clk);
        issue(32'd50, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        do_reset(2);
        repeat (3) @(negedge clk);
        issue(32'd50, 32'd5, 1'b0);
        wait_free();

`ifdef DIV_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_free();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_free();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_free();
        issue(32'hFFFF_FFF9, 32'd0, 1'b1);
        wait_free();
`endif

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 16);
                3:       b = a;
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'b0;
`ifdef DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`endif
            wait_free();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b, s);
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
